// File: rtl/core_lock_monitor.sv
// core_lock_monitor: per-core LP lock tracking between the event dispatcher
// and the core array. Stalls cores whose LP is held elsewhere, hands the lock
// to the oldest waiter on retire, forwards history sizes and reports the
// minimum active timestamp for GVT.
module core_lock_monitor #(
   parameter int NUM_CORE      = 8,
   parameter int NB_COREID     = $clog2(NUM_CORE),
   parameter int NUM_LP        = 64,
   parameter int NB_LPID       = $clog2(NUM_LP),
   parameter int TIME_WID      = 16,
   parameter int NB_HIST_DEPTH = 4,
   parameter int CNT_WID       = 16
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              disp_vld,
   input  logic [NB_COREID-1:0]              disp_core_id,
   input  logic [NB_LPID-1:0]                disp_lp_id,
   input  logic [TIME_WID-1:0]               disp_time,
   input  logic                              ret_vld,
   input  logic [NB_COREID-1:0]              ret_core_id,
   input  logic [NB_HIST_DEPTH-1:0]          ret_hist_size,
   input  logic                              cnt_clr,
   output logic [NUM_CORE-1:0]               stall,
   output logic [NUM_CORE-1:0]               wake,
   output logic [TIME_WID-1:0]               min_time,
   output logic                              min_time_vld,
   output logic [NB_HIST_DEPTH*NUM_CORE-1:0] core_hist_cnt,
   output logic [CNT_WID*NUM_CORE-1:0]       stall_cnt,
   output logic                              err
);

   logic [NUM_CORE-1:0]      active_q, active_d;
   logic [NUM_CORE-1:0]      stall_q, stall_d;
   logic [NUM_CORE-1:0]      wake_q, wake_d;
   logic                     err_q, err_d;
   logic [NB_LPID-1:0]       lp_q        [NUM_CORE];
   logic [NB_LPID-1:0]       lp_d        [NUM_CORE];
   logic [TIME_WID-1:0]      time_q      [NUM_CORE];
   logic [TIME_WID-1:0]      time_d      [NUM_CORE];
   logic [NB_HIST_DEPTH-1:0] core_hist_q [NUM_CORE];
   logic [NB_HIST_DEPTH-1:0] core_hist_d [NUM_CORE];
   logic [CNT_WID-1:0]       cnt_q       [NUM_CORE];
   logic [CNT_WID-1:0]       cnt_d       [NUM_CORE];
   logic [NB_HIST_DEPTH-1:0] lp_hist_q   [NUM_LP];
   logic [NB_HIST_DEPTH-1:0] lp_hist_d   [NUM_LP];

   // Scratch values of the next-state computation
   logic [NB_LPID-1:0]       ret_lp;
   logic                     ret_active;
   logic                     disp_active;
   logic [NUM_CORE-1:0]      win_oh;
   logic                     win_found;
   logic [TIME_WID-1:0]      win_time;
   logic                     holder;
   logic [NB_HIST_DEPTH-1:0] disp_hist;

   // Next state: retire (with lock hand-off) first, then dispatch against the post-retire view
   always_comb begin
      active_d    = active_q;
      stall_d     = stall_q;
      wake_d      = '0;
      err_d       = err_q;
      lp_d        = lp_q;
      time_d      = time_q;
      core_hist_d = core_hist_q;
      lp_hist_d   = lp_hist_q;
      ret_lp      = '0;
      ret_active  = 1'b0;
      disp_active = 1'b0;
      win_oh      = '0;
      win_found   = 1'b0;
      win_time    = '0;
      holder      = 1'b0;
      disp_hist   = '0;

      // Looked up by loop so out-of-range ids (NUM_CORE not a power of two) read as inactive
      for (int i = 0; i < NUM_CORE; i++) begin
         if (NB_COREID'(i) == ret_core_id) begin
            ret_lp     = lp_q[i];
            ret_active = active_q[i];
         end
         if (NB_COREID'(i) == disp_core_id) begin
            disp_active = active_q[i];
         end
      end

      // Oldest waiter on the retiring LP; strict compare keeps the lowest id on ties
      for (int i = 0; i < NUM_CORE; i++) begin
         if (ret_vld && active_q[i] && stall_q[i] && (lp_q[i] == ret_lp) &&
             (NB_COREID'(i) != ret_core_id)) begin
            if (!win_found || (time_q[i] < win_time)) begin
               win_found = 1'b1;
               win_time  = time_q[i];
               win_oh    = '0;
               win_oh[i] = 1'b1;
            end
         end
      end

      if (ret_vld) begin
         if (!ret_active) begin
            err_d = 1'b1;
         end
         for (int i = 0; i < NUM_CORE; i++) begin
            if (NB_COREID'(i) == ret_core_id) begin
               active_d[i] = 1'b0;
               stall_d[i]  = 1'b0;
            end
            if (win_oh[i]) begin
               stall_d[i]     = 1'b0;
               core_hist_d[i] = ret_hist_size;
            end
         end
         for (int j = 0; j < NUM_LP; j++) begin
            if (NB_LPID'(j) == ret_lp) begin
               lp_hist_d[j] = ret_hist_size;
            end
         end
         wake_d = win_oh;
      end

      // History size for the dispatched core, bypassing a same-cycle retire on that LP
      for (int j = 0; j < NUM_LP; j++) begin
         if (NB_LPID'(j) == disp_lp_id) begin
            disp_hist = lp_hist_q[j];
         end
      end
      if (ret_vld && (ret_lp == disp_lp_id)) begin
         disp_hist = ret_hist_size;
      end

      // Any other core still active on the LP (woken cores included) holds the lock
      for (int i = 0; i < NUM_CORE; i++) begin
         if ((NB_COREID'(i) != disp_core_id) && active_d[i] && (lp_q[i] == disp_lp_id)) begin
            holder = 1'b1;
         end
      end

      if (disp_vld) begin
         if (disp_active && !(ret_vld && (ret_core_id == disp_core_id))) begin
            err_d = 1'b1;
         end
         for (int i = 0; i < NUM_CORE; i++) begin
            if (NB_COREID'(i) == disp_core_id) begin
               active_d[i]    = 1'b1;
               stall_d[i]     = holder;
               lp_d[i]        = disp_lp_id;
               time_d[i]      = disp_time;
               core_hist_d[i] = disp_hist;
            end
         end
      end
   end

   // Stall-cycle counters: count on the registered stall, saturate, clear wins
   always_comb begin
      for (int i = 0; i < NUM_CORE; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr) begin
            cnt_d[i] = '0;
         end else if (stall_q[i] && !(&cnt_q[i])) begin
            cnt_d[i] = cnt_q[i] + CNT_WID'(1);
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= '0;
         stall_q  <= '0;
         wake_q   <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_CORE; i++) begin
            lp_q[i]        <= '0;
            time_q[i]      <= '0;
            core_hist_q[i] <= '0;
            cnt_q[i]       <= '0;
         end
         for (int j = 0; j < NUM_LP; j++) begin
            lp_hist_q[j] <= '0;
         end
      end else begin
         active_q    <= active_d;
         stall_q     <= stall_d;
         wake_q      <= wake_d;
         err_q       <= err_d;
         lp_q        <= lp_d;
         time_q      <= time_d;
         core_hist_q <= core_hist_d;
         cnt_q       <= cnt_d;
         lp_hist_q   <= lp_hist_d;
      end
   end

   // Minimum timestamp over active cores, zero when none are active
   always_comb begin
      min_time     = '0;
      min_time_vld = 1'b0;
      for (int i = 0; i < NUM_CORE; i++) begin
         if (active_q[i] && (!min_time_vld || (time_q[i] < min_time))) begin
            min_time     = time_q[i];
            min_time_vld = 1'b1;
         end
      end
   end

   assign stall = stall_q;
   assign wake  = wake_q;
   assign err   = err_q;

   for (genvar gi = 0; gi < NUM_CORE; gi++) begin : g_pack
      assign core_hist_cnt[gi*NB_HIST_DEPTH +: NB_HIST_DEPTH] = core_hist_q[gi];
      assign stall_cnt[gi*CNT_WID +: CNT_WID]                 = cnt_q[gi];
   end

endmodule
